// File: rtl/instr_loader_pkg.sv
// Shared debug-unit definitions: command codes, status bytes and the
// program-loader state encoding.
package instr_loader_pkg;

  localparam logic [7:0] CMD_LOAD     = 8'h07;
  localparam logic [7:0] STATUS_READY = 8'h52;
  localparam logic [7:0] STATUS_ERR   = 8'h45;

  typedef logic [2:0] state_t;

  localparam state_t IDLE        = 3'd0;
  localparam state_t WAIT_COUNT  = 3'd1;
  localparam state_t RECV        = 3'd2;
  localparam state_t WRITE       = 3'd3;
  localparam state_t SEND_STATUS = 3'd4;
  localparam state_t WAIT_TX     = 3'd5;

endpackage

// File: rtl/loader_timeout.sv
// Saturating inter-byte idle counter; o_expired stays high once LIMIT idle
// cycles have elapsed since the last clear.
module loader_timeout #(
  parameter int unsigned LIMIT = 2000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      count_q <= '0;
    end else if (count_q != W'(LIMIT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_expired = (count_q == W'(LIMIT));

endmodule

// File: rtl/instr_loader.sv
// Debug program loader: receives a word count and little-endian instruction
// bytes from the UART, writes them to instruction memory and reports status.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned SIZE            = 32,
  parameter int unsigned MAX_INSTRUCTION = 64,
  parameter int unsigned ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
  parameter int unsigned TIMEOUT_CYCLES  = 2000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_tx_done,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [SIZE-1:0]       o_mem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_instr_count,
  output state_t                o_state
);

  // Handshake: i_rx_valid and i_tx_done are single-cycle strobes with no
  // back-pressure; o_tx_start is a level held until the i_tx_done strobe.
  localparam int unsigned BYTES = SIZE / 8;
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t                state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d, word_next;
  logic [BW-1:0]         byte_idx_q, byte_idx_d, cur_byte;
  logic [SIZE-1:0]       asm_q, asm_d;
  logic [7:0]            status_q, status_d;
  logic [7:0]            tx_data_d;
  logic                  tx_start_d, mem_we_d, busy_d, done_d, error_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [SIZE-1:0]       mem_data_d;
  logic [ADDR_WIDTH:0]   instr_count_d;
  logic                  tmo_clr, tmo_expired;
  logic                  last_word, capture, word_full, count_bad;

  loader_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (tmo_clr),
    .o_expired (tmo_expired)
  );

  assign tmo_clr   = !(state_q == WAIT_COUNT || state_q == RECV) || i_rx_valid;
  assign word_next = word_idx_q + 1'b1;
  assign last_word = (32'(word_next) == 32'(n_q));
  // A byte arriving during WRITE belongs to the next word, if there is one.
  assign capture   = i_rx_valid && (state_q == RECV || (state_q == WRITE && !last_word));
  assign cur_byte  = (state_q == WRITE) ? '0 : byte_idx_q;
  assign word_full = capture && (32'(cur_byte) == BYTES - 1);
  assign count_bad = (32'(i_rx_data) > MAX_INSTRUCTION);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (i_start) state_d = WAIT_COUNT;
      WAIT_COUNT: begin
        if (i_rx_valid) state_d = (i_rx_data == 8'd0 || count_bad) ? SEND_STATUS : RECV;
        else if (tmo_expired) state_d = SEND_STATUS;
      end
      RECV: begin
        if (word_full) state_d = WRITE;
        else if (!i_rx_valid && tmo_expired) state_d = SEND_STATUS;
      end
      WRITE: begin
        if (last_word)      state_d = SEND_STATUS;
        else if (word_full) state_d = WRITE;
        else                state_d = RECV;
      end
      SEND_STATUS: state_d = WAIT_TX;
      WAIT_TX:     if (i_tx_done) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    n_d           = n_q;
    word_idx_d    = word_idx_q;
    byte_idx_d    = byte_idx_q;
    asm_d         = asm_q;
    status_d      = status_q;
    tx_data_d     = o_tx_data;
    tx_start_d    = o_tx_start;
    mem_we_d      = 1'b0;
    mem_addr_d    = o_mem_addr;
    mem_data_d    = o_mem_data;
    busy_d        = o_busy;
    done_d        = 1'b0;
    error_d       = o_error;
    instr_count_d = o_instr_count;

    if (capture) begin
      asm_d[8*int'(cur_byte) +: 8] = i_rx_data;
      byte_idx_d = word_full ? '0 : cur_byte + 1'b1;
    end else if (state_q == WRITE) begin
      byte_idx_d = '0;
    end
    if (word_full) begin
      mem_we_d   = 1'b1;
      mem_data_d = asm_d;
      mem_addr_d = (state_q == WRITE) ? word_next[ADDR_WIDTH-1:0] : word_idx_q[ADDR_WIDTH-1:0];
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          busy_d     = 1'b1;
          error_d    = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end
      WAIT_COUNT: begin
        if (i_rx_valid) begin
          n_d = i_rx_data;
          if (i_rx_data == 8'd0) begin
            status_d      = STATUS_READY;
            instr_count_d = '0;
          end else if (count_bad) begin
            status_d      = STATUS_ERR;
            error_d       = 1'b1;
            instr_count_d = '0;
          end
        end else if (tmo_expired) begin
          status_d      = STATUS_ERR;
          error_d       = 1'b1;
          instr_count_d = word_idx_q;
        end
      end
      RECV: begin
        if (!i_rx_valid && tmo_expired) begin
          status_d      = STATUS_ERR;
          error_d       = 1'b1;
          instr_count_d = word_idx_q;
        end
      end
      WRITE: begin
        word_idx_d = word_next;
        if (last_word) begin
          status_d      = STATUS_READY;
          instr_count_d = word_next;
        end
      end
      SEND_STATUS: begin
        tx_data_d  = status_q;
        tx_start_d = 1'b1;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          tx_start_d = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n_q           <= '0;
      word_idx_q    <= '0;
      byte_idx_q    <= '0;
      asm_q         <= '0;
      status_q      <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_data    <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_instr_count <= '0;
    end else begin
      n_q           <= n_d;
      word_idx_q    <= word_idx_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      status_q      <= status_d;
      o_tx_data     <= tx_data_d;
      o_tx_start    <= tx_start_d;
      o_mem_we      <= mem_we_d;
      o_mem_addr    <= mem_addr_d;
      o_mem_data    <= mem_data_d;
      o_busy        <= busy_d;
      o_done        <= done_d;
      o_error       <= error_d;
      o_instr_count <= instr_count_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized loads compared against a
// byte-list reference model and a write scoreboard.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int TMO  = 100;
  localparam int MAXI = 64;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          rst, start, rx_valid, tx_done;
  logic [7:0]    rx_data;
  logic [7:0]    tx_data;
  logic          tx_start, mem_we, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic [AW:0]   instr_count;
  state_t        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] got_q[$];
  logic [7:0]     bytes_q[$];

  instr_loader #(.SIZE(32), .MAX_INSTRUCTION(MAXI), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .i_tx_done     (tx_done),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_data    (mem_data),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error),
    .o_instr_count (instr_count),
    .o_state       (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_data});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    bytes_q.delete();
    for (int i = 0; i < 4 * n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic start_load;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %b want 1", busy); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL start_err_clear: got %b want 0", error); end
  endtask

  task automatic send_count(input int n, input int gap);
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = 8'(n);
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends bytes_q (or its first stop_after bytes); model pushes a word per 4 bytes.
  task automatic send_stream(input int max_gap, input int stop_after, input bit poke_start);
    int nb, gap, w;
    logic [31:0] w32;
    nb = (stop_after >= 0) ? stop_after : bytes_q.size();
    for (int i = 0; i < nb; i++) begin
      gap = $urandom_range(0, max_gap);
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) tick();
      end
      rx_valid = 1'b1;
      rx_data  = bytes_q[i];
      start    = poke_start && (i == 5);
      tick();
      start = 1'b0;
      if (i % 4 == 3) begin
        w   = i / 4;
        w32 = 32'(bytes_q[i-3]) + 32'(bytes_q[i-2]) * 32'd256
            + 32'(bytes_q[i-1]) * 32'd65536 + 32'(bytes_q[i]) * 32'd16777216;
        exp_q.push_back({AW'(w), w32});
        total++;
        if (mem_we !== 1'b1 || mem_addr !== AW'(w) || mem_data !== w32) begin
          bad++;
          $display("FAIL write_latency: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                   mem_we, mem_addr, mem_data, w, w32);
        end
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic finish_load(input logic [7:0] exp_status, input bit exp_err, input int exp_cnt,
                             input int exp_lat, input string name);
    int waited, hold;
    logic [AW+31:0] e, g;
    waited = 0;
    while (tx_start !== 1'b1 && waited < 1000) begin tick(); waited++; end
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL %s_tx_start: got %b want 1", name, tx_start); end
    if (exp_lat >= 0) begin
      total++; if (waited != exp_lat) begin bad++; $display("FAIL %s_tx_latency: got %0d want %0d", name, waited, exp_lat); end
    end
    total++; if (tx_data !== exp_status) begin bad++; $display("FAIL %s_status: got %h want %h", name, tx_data, exp_status); end
    hold = $urandom_range(0, 4);
    repeat (hold) begin
      tick();
      total++; if (tx_start !== 1'b1 || tx_data !== exp_status) begin bad++; $display("FAIL %s_tx_hold: got start=%b data=%h want 1/%h", name, tx_start, tx_data, exp_status); end
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL %s_done: got %b want 1", name, done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end: got %b want 0", name, busy); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL %s_tx_release: got %b want 0", name, tx_start); end
    total++; if (error !== exp_err) begin bad++; $display("FAIL %s_error: got %b want %b", name, error, exp_err); end
    if (exp_cnt >= 0) begin
      total++; if (instr_count !== (AW+1)'(exp_cnt)) begin bad++; $display("FAIL %s_count: got %0d want %0d", name, instr_count, exp_cnt); end
    end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse: got %b want 0", name, done); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL %s_write_count: got %0d want %0d", name, got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL %s_write: got %h want %h", name, g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    total++; if ({busy, done, mem_we, tx_start, error} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {busy, done, mem_we, tx_start, error}); end
    total++; if (tx_data !== 8'h00 || mem_addr !== '0 || mem_data !== '0 || instr_count !== '0) begin
      bad++; $display("FAIL reset_values: got tx=%h addr=%0d data=%h cnt=%0d want zeros", tx_data, mem_addr, mem_data, instr_count);
    end
  endtask

  task automatic test_basic;
    bytes_q = '{8'h0F, 8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h01, 8'hA0};
    start_load();
    send_count(2, 1);
    send_stream(2, -1, 1'b0);
    finish_load(STATUS_READY, 1'b0, 2, -1, "basic");
  endtask

  task automatic test_zero;
    start_load();
    send_count(0, 0);
    finish_load(STATUS_READY, 1'b0, 0, 1, "zero");
  endtask

  task automatic test_overflow;
    start_load();
    send_count(MAXI + 1, 2);
    finish_load(STATUS_ERR, 1'b1, -1, 1, "overflow");
    fill_random(1);
    start_load();
    send_count(1, 0);
    send_stream(1, -1, 1'b0);
    finish_load(STATUS_READY, 1'b0, 1, -1, "after_overflow");
    fill_random(MAXI);
    start_load();
    send_count(MAXI, 0);
    send_stream(0, -1, 1'b0);
    finish_load(STATUS_READY, 1'b0, MAXI, -1, "max_count");
  endtask

  task automatic test_timeout;
    fill_random(3);
    start_load();
    send_count(3, 1);
    send_stream(1, 6, 1'b0);
    repeat (TMO - 5) tick();
    total++; if (tx_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL no_early_timeout: got start=%b busy=%b want 0/1", tx_start, busy); end
    finish_load(STATUS_ERR, 1'b1, 1, -1, "timeout");
  endtask

  task automatic test_back_to_back;
    fill_random(2);
    start_load();
    rx_valid = 1'b1;
    rx_data  = 8'd2;
    tick();
    send_stream(0, -1, 1'b0);
    finish_load(STATUS_READY, 1'b0, 2, -1, "b2b");
  endtask

  task automatic test_start_collisions;
    rx_valid = 1'b1;
    rx_data  = 8'd2;
    tick();
    rx_valid = 1'b0;
    total++; if (busy !== 1'b0 || dbg_state !== IDLE) begin bad++; $display("FAIL idle_rx_ignored: got busy=%b state=%0d want 0/%0d", busy, dbg_state, IDLE); end
    fill_random(2);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'd5;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    total++; if (dbg_state !== WAIT_COUNT) begin bad++; $display("FAIL start_with_rx: got state %0d want %0d", dbg_state, WAIT_COUNT); end
    send_count(2, 1);
    send_stream(2, -1, 1'b1);
    finish_load(STATUS_READY, 1'b0, 2, -1, "busy_start");
  endtask

  task automatic test_reset_mid;
    fill_random(3);
    start_load();
    send_count(3, 0);
    send_stream(1, 2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({busy, tx_start, mem_we, error} !== 4'b0 || dbg_state !== IDLE) begin
      bad++; $display("FAIL reset_mid: got flags=%b state=%0d want 0000/%0d", {busy, tx_start, mem_we, error}, dbg_state, IDLE);
    end
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    repeat (6) tick();
    rx_valid = 1'b0;
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL reset_mid_writes: got %0d want 0", got_q.size()); end
    got_q.delete();
    fill_random(2);
    start_load();
    send_count(2, 1);
    send_stream(3, -1, 1'b0);
    finish_load(STATUS_READY, 1'b0, 2, -1, "post_reset");
  endtask

  task automatic test_random;
    int n;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 8);
      fill_random(n);
      start_load();
      send_count(n, $urandom_range(0, 3));
      send_stream(3, -1, 1'b0);
      finish_load(STATUS_READY, 1'b0, n, -1, "random");
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_done  = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_start_collisions();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Debug-unit program loader. It sits directly downstream of the UART receiver and the debug command decoder, and upstream of instruction memory.
- After the decoder sees command 0x07, this block takes an instruction-count byte, then 4 bytes per instruction (little-endian, LSB first).
- It writes each assembled word to consecutive instruction-memory word addresses.
- It then hands one status byte to the UART transmitter: 'R' (0x52) on success, 'E' (0x45) on error.

Parameters:
- SIZE, 32, instruction word width; must be a multiple of 8.
- MAX_INSTRUCTION, 64, maximum instructions per load (instruction memory depth in words).
- ADDR_WIDTH, $clog2(MAX_INSTRUCTION), instruction-memory word-address width.
- TIMEOUT_CYCLES, 2000000, maximum idle clocks allowed between bytes during a load before abort.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse from the command decoder on receipt of 0x07.
- i_rx_data  in  8  UART receiver byte.
- i_rx_valid  in  1  one-cycle pulse; i_rx_data is valid this cycle.
- i_tx_done  in  1  UART transmitter finished the current byte (one-cycle pulse).
- o_tx_data  out  8  status byte to send.
- o_tx_start  out  1  request to send o_tx_data; held until i_tx_done.
- o_mem_we  out  1  instruction-memory write enable, one cycle per word.
- o_mem_addr  out  ADDR_WIDTH  word address to write.
- o_mem_data  out  SIZE  assembled instruction word.
- o_busy  out  1  high from accepted i_start until the status byte is done.
- o_done  out  1  one-cycle pulse when the load ends (success or error).
- o_error  out  1  sticky; set on count overflow or timeout, cleared on the next accepted i_start.
- o_instr_count  out  ADDR_WIDTH+1  instructions successfully written in the last load.

Behaviour:
- Reset values:
  - state IDLE.
  - o_busy, o_done, o_mem_we, o_tx_start, o_error all 0.
  - o_tx_data 0, o_mem_addr 0, o_mem_data 0, o_instr_count 0.
- All outputs are registered.
- Reset mid-operation: returns to IDLE on the next edge; no further writes; any pending tx request is dropped.
- IDLE:
  - i_rx_valid is ignored.
  - On i_start: go to WAIT_COUNT; o_busy=1; o_error=0; word index=0; byte index=0; timeout counter cleared.
- WAIT_COUNT: on i_rx_valid, latch N=i_rx_data, then branch:
  - N==0: go to SEND_STATUS with 'R'; o_instr_count=0.
  - N>MAX_INSTRUCTION: go to SEND_STATUS with 'E'; o_error=1; no writes.
  - Otherwise: go to RECV.
- RECV:
  - On i_rx_valid, shift the byte into lane [8*byte_idx +: 8] of the assembly register.
  - When byte_idx==SIZE/8-1, go to WRITE; otherwise byte_idx+1.
- WRITE (exactly one cycle):
  - o_mem_we=1, o_mem_addr=word_idx, o_mem_data=assembled word.
  - Then word_idx+1 and byte_idx=0.
  - If word_idx+1==N: go to SEND_STATUS with 'R' and set o_instr_count=N. Otherwise return to RECV.
  - An i_rx_valid arriving during WRITE is captured as byte 0 of the next word and must not be lost.
- Latency: o_mem_we asserts 1 cycle after the i_rx_valid carrying the last byte of a word.
- Timeout:
  - In WAIT_COUNT and RECV, the counter increments every cycle without i_rx_valid and clears on each i_rx_valid.
  - Reaching TIMEOUT_CYCLES goes to SEND_STATUS with 'E'; o_error=1; o_instr_count = words already written.
  - Words already written are not rolled back.
- SEND_STATUS: o_tx_data = status byte, o_tx_start=1; go to WAIT_TX.
- WAIT_TX:
  - Hold o_tx_start and o_tx_data until i_tx_done.
  - Then o_tx_start=0, o_done pulses 1 cycle, o_busy=0, go to IDLE.
- i_start while o_busy: ignored.
- i_start and i_rx_valid in the same cycle in IDLE: the start is taken and the byte ignored.
- Address never wraps; word_idx < N <= MAX_INSTRUCTION is guaranteed by the count check.

Decomposition:
- Shared debug package holds:
  - command codes CMD_LOAD=8'h07;
  - status bytes STATUS_READY=8'h52 and STATUS_ERR=8'h45;
  - state encoding localparams IDLE, WAIT_COUNT, RECV, WRITE, SEND_STATUS, WAIT_TX.
- One natural sub-module: loader_timeout, a resettable saturating counter with a clear input and a terminal-count flag.
- Byte assembly stays inline.

Test Plan:
- Start, N=2, bytes 0F 00 01 20, 00 00 01 A0 -> writes 0x2001000F@0 and 0xA0010000@1; tx 'R'; o_instr_count=2; o_error=0.
- Start, N=0 -> no o_mem_we; tx 'R' immediately after the count byte; o_done pulse.
- Start, N=65 (MAX_INSTRUCTION=64) -> no writes; tx 'E'; o_error=1; next start with N=1 clears o_error.
- Start, N=3, with a TIMEOUT_CYCLES gap after word 1's 2nd byte (TIMEOUT_CYCLES=100 in bench) -> word 0 written only; tx 'E'; o_instr_count=1.
- Back-to-back i_rx_valid every cycle including during WRITE, N=2 -> both words correct; no byte dropped.
- i_rst asserted while in RECV -> outputs return to reset values next cycle; a later start/load behaves normally.
